// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;
  localparam logic [BE_W-1:0] BE_B0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_B1   = 4'b0010;
  localparam logic [BE_W-1:0] BE_B2   = 4'b0100;
  localparam logic [BE_W-1:0] BE_B3   = 4'b1000;

  // MEM/WB register payload
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] readdata;
    logic [REG_W-1:0]  writereg;
    logic              align_err;
    logic              bus_err;
  } wb_t;

  // Byte-lane enable for a byte access at the given offset
  function automatic logic [BE_W-1:0] byte_be(input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (off)
      2'd0:    be = BE_B0;
      2'd1:    be = BE_B1;
      2'd2:    be = BE_B2;
      default: be = BE_B3;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte lane of load data and sign/zero-extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic              is_byte,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] readdata
);

  logic [7:0] lane;

  always_comb begin
    lane     = rdata[7:0];
    readdata = rdata;
    case (addr)
      2'd0:    lane = rdata[7:0];
      2'd1:    lane = rdata[15:8];
      2'd2:    lane = rdata[23:16];
      default: lane = rdata[31:24];
    endcase
    if (is_byte) begin
      if (is_unsigned) readdata = {{(DATA_W-8){1'b0}}, lane};
      else             readdata = {{(DATA_W-8){lane[7]}}, lane};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: req/ack data-memory access, pipeline stall and MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_m,
  input  logic              memread_m,
  input  logic              memwrite_m,
  input  logic              byte_m,
  input  logic              unsigned_m,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic [DATA_W-1:0] aluout_m,
  input  logic [DATA_W-1:0] writedata_m,
  input  logic [REG_W-1:0]  writereg_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_m,
  output logic              valid_w,
  output logic              regwrite_w,
  output logic              memtoreg_w,
  output logic [DATA_W-1:0] aluout_w,
  output logic [DATA_W-1:0] readdata_w,
  output logic [REG_W-1:0]  writereg_w,
  output logic              align_err_w,
  output logic              bus_err_w
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_d, we_d;
  logic [DATA_W-1:0] addr_d, wdata_d;
  logic [BE_W-1:0]   be_d;
  wb_t               wb_q, wb_d, cap;
  logic              acc, mis, stall_c;
  logic [DATA_W-1:0] load_data;

  assign acc = valid_m & (memread_m | memwrite_m);
  assign mis = acc & ~byte_m & (aluout_m[1:0] != 2'b00);

  load_align u_load_align (
    .rdata       (mem_rdata),
    .addr        (aluout_m[1:0]),
    .is_byte     (byte_m),
    .is_unsigned (unsigned_m),
    .readdata    (load_data)
  );

  // Plain capture of the EX/MEM inputs into the MEM/WB payload
  always_comb begin
    cap           = '0;
    cap.valid     = valid_m;
    cap.regwrite  = valid_m & regwrite_m;
    cap.memtoreg  = memtoreg_m;
    cap.aluout    = aluout_m;
    cap.writereg  = writereg_m;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wb_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_be    <= be_d;
      wb_q      <= wb_d;
    end
  end

  // Next state, request registers and MEM/WB load; wb_d stays a bubble while stalled
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    be_d    = mem_be;
    stall_c = 1'b0;
    wb_d    = '0;
    case (state_q)
      IDLE: begin
        if (acc && !mis) begin
          stall_c = 1'b1;
          we_d    = memwrite_m;
          addr_d  = {aluout_m[DATA_W-1:2], 2'b00};
          be_d    = byte_m ? byte_be(aluout_m[1:0]) : BE_WORD;
          wdata_d = byte_m ? {BE_W{writedata_m[7:0]}} : writedata_m;
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = ACCESS;
        end else begin
          wb_d = cap;
          if (mis) begin
            wb_d.align_err = 1'b1;
            wb_d.regwrite  = 1'b0;
          end
        end
      end
      ACCESS: begin
        cnt_d   = cnt_q + CNT_W'(1);
        stall_c = 1'b1;
        if (mem_ack) begin
          stall_c       = 1'b0;
          wb_d          = cap;
          wb_d.readdata = load_data;
          req_d         = 1'b0;
          state_d       = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          stall_c       = 1'b0;
          wb_d          = cap;
          wb_d.bus_err  = 1'b1;
          wb_d.regwrite = 1'b0;
          req_d         = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_m     = stall_c & ~reset;
  assign valid_w     = wb_q.valid;
  assign regwrite_w  = wb_q.regwrite;
  assign memtoreg_w  = wb_q.memtoreg;
  assign aluout_w    = wb_q.aluout;
  assign readdata_w  = wb_q.readdata;
  assign writereg_w  = wb_q.writereg;
  assign align_err_w = wb_q.align_err;
  assign bus_err_w   = wb_q.bus_err;

endmodule
